ffcp_tx_server: RTL

Transmit-side flow controller for FFCP: a go-back-N sliding-window sequencer that decides which packet index the FFCP transmit framer sends next, and with which type. It sits between the upstream packet ring buffer (slot = index mod WINDOW_LEN) and the FFCP transmit framer. It consumes cumulative acks from the FFCP receive path and retransmits on timeout. Sends a SYN at index 0 after reset, then MSG packets once the link is acknowledged.

---
 rtl/ffcp_tx_server_pkg.sv | 39 +++
 rtl/ffcp_tx_timer.sv | 51 +++++
 rtl/ffcp_tx_server.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ffcp_tx_server_pkg.sv
// -----------------------------------------------------------------------------
// ffcp_tx_server_pkg
//
// Shared FFCP networking definitions used by the transmit flow controller:
// field widths, default window/index sizes, packet type codes, the FSM state
// type and a constant-foldable clog2 helper for sizing ports and counters.
// -----------------------------------------------------------------------------
package ffcp_tx_server_pkg;

  localparam int FFCP_TYPE_LEN       = 2;
  localparam int FFCP_INDEX_LEN      = 6;
  localparam int FFCP_WINDOW_LEN     = 8;
  localparam int FFCP_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [FFCP_TYPE_LEN-1:0] {
    FFCP_TYPE_SYN = 2'd0,
    FFCP_TYPE_MSG = 2'd1,
    FFCP_TYPE_ACK = 2'd2
  } ffcp_type_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage : ffcp_tx_server_pkg

// File: rtl/ffcp_tx_timer.sv
// -----------------------------------------------------------------------------
// ffcp_tx_timer
//
// Retransmit timer for the FFCP transmit flow controller. Counts cycles while
// run_i is high; expire_o pulses on the cycle the count reaches
// TIMEOUT_CYCLES-1, after which the count restarts from zero.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   run_i     count enable (packets outstanding)
//   clear_i   restart the count from zero (ack progress or go-back applied)
//   expire_o  one-cycle pulse at the terminal count while running
// -----------------------------------------------------------------------------
module ffcp_tx_timer
  import ffcp_tx_server_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = FFCP_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // expire is independent of clear_i so the parent can arbitrate ack vs.
  // timeout without a combinational loop through the clear path.
  assign expire_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || !run_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : ffcp_tx_timer

// File: rtl/ffcp_tx_server.sv
// -----------------------------------------------------------------------------
// ffcp_tx_server
//
// Go-back-N transmit sequencer for FFCP. Chooses which packet index the
// transmit framer sends next (SYN at index 0 until the link is acknowledged,
// MSG afterwards), tracks the window [base, top) against cumulative acks and
// rewinds to base when the retransmit timer expires.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (shared with framer)
//   data_avail   upstream has a packet committed in slot top[SLOT_W-1:0]
//   new_outclk   pulse: a new packet was accepted (top advanced)
//   tx_start     pulse: start the framer
//   tx_type      packet type (SYN/MSG), held from tx_start until tx_done
//   tx_index     packet index, held likewise
//   tx_slot      ring slot to read (low bits of tx_index)
//   tx_done      framer finished the current packet
//   ack_inclk    cumulative ack valid
//   ack_index    next index the receiver expects
//   inflight     top - base (upstream may only write slots outside the window)
//   link_up      a valid ack has been seen since reset
//   retx_count   (FFCP_TX_STATS_EN only) saturating count of timeout go-backs
//
// Build option: define FFCP_TX_STATS_EN to add the retx_count output.
// -----------------------------------------------------------------------------
module ffcp_tx_server
  import ffcp_tx_server_pkg::*;
#(
  parameter int INDEX_LEN      = FFCP_INDEX_LEN,
  parameter int WINDOW_LEN     = FFCP_WINDOW_LEN,
  parameter int TIMEOUT_CYCLES = FFCP_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_avail,
  output logic                          new_outclk,
  output logic                          tx_start,
  output logic [FFCP_TYPE_LEN-1:0]      tx_type,
  output logic [INDEX_LEN-1:0]          tx_index,
  output logic [clog2(WINDOW_LEN)-1:0]  tx_slot,
  input  logic                          tx_done,
  input  logic                          ack_inclk,
  input  logic [INDEX_LEN-1:0]          ack_index,
  output logic [clog2(WINDOW_LEN):0]    inflight,
  output logic                          link_up
`ifdef FFCP_TX_STATS_EN
  ,
  output logic [15:0]                   retx_count
`endif
);

  localparam int SLOT_W = clog2(WINDOW_LEN);
  localparam int CNT_W  = SLOT_W + 1;

  typedef logic [INDEX_LEN-1:0] idx_t;

  tx_state_e  state_q, state_d;
  idx_t       base_q, base_d;
  idx_t       next_q, next_d;
  idx_t       top_q, top_d;
  idx_t       tx_index_q, tx_index_d;
  ffcp_type_e tx_type_q, tx_type_d;
  logic       link_up_q, link_up_d;
  logic       retx_pend_q, retx_pend_d;
  logic       tx_start_q, tx_start_d;
  logic       new_outclk_q, new_outclk_d;

  idx_t             span;
  idx_t             ack_dist;
  idx_t             eff_next;
  idx_t             next_adv;
  idx_t             next_rel;
  logic [CNT_W-1:0] inflight_w;
  logic [CNT_W-1:0] limit;
  logic             ack_valid;
  logic             expire;
  logic             expire_ok;
  logic             retx_req;
  logic             apply_retx;
  logic             is_new;
  logic             launch;

  // All window arithmetic is relative to base, modulo 2^INDEX_LEN, so index
  // wrap-around never needs special casing.
  assign span       = top_q - base_q;
  assign inflight_w = CNT_W'(span);
  assign ack_dist   = ack_index - base_q;
  assign ack_valid  = ack_inclk && (ack_dist != '0) && (ack_dist <= span);
  assign limit      = link_up_q ? CNT_W'(WINDOW_LEN) : CNT_W'(1);

  // A valid ack in the same cycle as an expiry (or while a go-back is still
  // waiting for the current packet to finish) cancels the go-back.
  assign expire_ok  = expire && !ack_valid;
  assign retx_req   = retx_pend_q || expire_ok;
  assign apply_retx = retx_req && !ack_valid &&
                      ((state_q == TX_IDLE) || tx_done);

  // A go-back applied in IDLE takes effect in the same cycle's launch choice.
  assign eff_next = apply_retx ? base_q : next_q;
  assign is_new   = (eff_next == top_q);
  assign launch   = (state_q == TX_IDLE) &&
                    (!is_new || (data_avail && (inflight_w < limit)));

  ffcp_tx_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run_i    (inflight_w != '0),
    .clear_i  (ack_valid || apply_retx),
    .expire_o (expire)
  );

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned; otherwise synthesis would infer a latch.
    state_d      = state_q;
    base_d       = base_q;
    top_d        = top_q;
    link_up_d    = link_up_q;
    tx_index_d   = tx_index_q;
    tx_type_d    = tx_type_q;
    tx_start_d   = 1'b0;
    new_outclk_d = 1'b0;
    next_adv     = eff_next;
    next_rel     = '0;

    unique case (state_q)
      TX_IDLE: begin
        if (launch) begin
          state_d    = TX_SEND;
          tx_start_d = 1'b1;
          tx_index_d = eff_next;
          tx_type_d  = ((eff_next == '0) && !link_up_q) ? FFCP_TYPE_SYN
                                                        : FFCP_TYPE_MSG;
          next_adv   = eff_next + idx_t'(1);
          if (is_new) begin
            new_outclk_d = 1'b1;
            top_d        = top_q + idx_t'(1);
          end
        end
      end
      TX_SEND: begin
        // The packet in flight completes unchanged even if an ack moves base.
        if (tx_done) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    next_d = next_adv;
    if (ack_valid) begin
      base_d    = ack_index;
      link_up_d = 1'b1;
      // Skip packets the receiver already holds.
      next_rel = next_adv - base_q;
      if (next_rel < ack_dist) begin
        next_d = ack_index;
      end
    end

    retx_pend_d = retx_req && !apply_retx && !ack_valid;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= TX_IDLE;
      base_q       <= '0;
      next_q       <= '0;
      top_q        <= '0;
      link_up_q    <= 1'b0;
      retx_pend_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      new_outclk_q <= 1'b0;
      tx_index_q   <= '0;
      tx_type_q    <= FFCP_TYPE_SYN;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      next_q       <= next_d;
      top_q        <= top_d;
      link_up_q    <= link_up_d;
      retx_pend_q  <= retx_pend_d;
      tx_start_q   <= tx_start_d;
      new_outclk_q <= new_outclk_d;
      tx_index_q   <= tx_index_d;
      tx_type_q    <= tx_type_d;
    end
  end

`ifdef FFCP_TX_STATS_EN
  logic [15:0] retx_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retx_count_q <= '0;
    end else if (apply_retx && (retx_count_q != 16'hFFFF)) begin
      retx_count_q <= retx_count_q + 16'd1;
    end
  end

  assign retx_count = retx_count_q;
`endif

  assign tx_start   = tx_start_q;
  assign new_outclk = new_outclk_q;
  assign tx_type    = tx_type_q;
  assign tx_index   = tx_index_q;
  assign tx_slot    = tx_index_q[SLOT_W-1:0];
  assign inflight   = inflight_w;
  assign link_up    = link_up_q;

endmodule : ffcp_tx_server
